// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline controller: FSM state encodings and
// the bit index of each controlled stage register.
package pipe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    // Bit positions inside StageEn / StageFlush
    localparam int STG_PC    = 0;
    localparam int STG_IFID  = 1;
    localparam int STG_IDEX  = 2;
    localparam int STG_EXMEM = 3;
    localparam int STG_MEMWB = 4;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Inc,
    output logic [W-1:0] Count
);

    logic [W-1:0] r_count;

    // Count up on Inc until saturated; synchronous active-low clear
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_count <= '0;
        end else if (Inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign Count = r_count;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: decides per cycle which stage registers
// load and which get a bubble, runs free or single-steps, and drains the
// pipe before stopping on a halt. Also keeps active/stall cycle counters.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int N_STAGES = 5,
    parameter int CNT_W    = 16
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                RunReq,
    input  logic                StepReq,
    input  logic                HaltReq,
    input  logic                HaltInstr,
    input  logic                HazardStall,
    input  logic                BranchTaken,
    output logic [N_STAGES-1:0] StageEn,
    output logic [N_STAGES-1:0] StageFlush,
    output logic [2:0]          State,
    output logic                Halted,
    output logic [CNT_W-1:0]    CycleCount,
    output logic [CNT_W-1:0]    StallCount
);

    localparam int DW = 4;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(N_STAGES - 2);
    // Freeze PC and IF/ID, keep everything from ID/EX onward moving
    localparam logic [N_STAGES-1:0] STALL_EN = {{(N_STAGES-2){1'b1}}, 2'b00};

    state_t              r_state;
    state_t              w_state_next;
    logic [DW-1:0]       r_drain_cnt;
    logic [DW-1:0]       w_drain_next;
    logic [N_STAGES-1:0] w_en;
    logic [N_STAGES-1:0] w_flush;
    logic                w_cyc_inc;
    logic                w_stall_inc;

    // State and drain counter registers
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state     <= ST_IDLE;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_drain_cnt <= w_drain_next;
        end
    end

    // Next-state, stage enables/flushes and counter increments
    always_comb begin
        w_state_next = r_state;
        w_drain_next = r_drain_cnt;
        w_en         = '0;
        w_flush      = '0;
        w_cyc_inc    = 1'b0;
        w_stall_inc  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (RunReq) begin
                    w_state_next = ST_RUN;
                end else if (StepReq) begin
                    w_state_next = ST_STEP;
                end
            end
            ST_RUN, ST_STEP: begin
                w_cyc_inc = 1'b1;
                if (HazardStall) begin
                    // Hold the instruction in ID, send a bubble down to EX
                    w_en               = STALL_EN;
                    w_flush[STG_IDEX]  = 1'b1;
                    w_stall_inc        = 1'b1;
                end else begin
                    w_en = '1;
                    if (BranchTaken) begin
                        w_flush[STG_IFID] = 1'b1;
                    end
                end
                // An external halt cannot be blocked by a stall; a HALT opcode
                // only counts once it is actually leaving ID
                if (HaltReq || (HaltInstr && !HazardStall)) begin
                    w_state_next = ST_DRAIN;
                    w_drain_next = DRAIN_LOAD;
                end else if ((r_state == ST_STEP) && !HazardStall) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                w_cyc_inc         = 1'b1;
                w_en              = STALL_EN;
                w_flush[STG_IDEX] = 1'b1;
                if (r_drain_cnt <= DW'(1)) begin
                    w_state_next = ST_HALTED;
                    w_drain_next = '0;
                end else begin
                    w_drain_next = r_drain_cnt - 1'b1;
                end
            end
            ST_HALTED: begin
                w_state_next = ST_HALTED;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        // Under reset nothing loads and every stage is bubbled
        if (!Reset) begin
            w_en    = '0;
            w_flush = '1;
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .Clock (Clock),
        .Reset (Reset),
        .Inc   (w_cyc_inc),
        .Count (CycleCount)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .Clock (Clock),
        .Reset (Reset),
        .Inc   (w_stall_inc),
        .Count (StallCount)
    );

    assign StageEn    = w_en;
    assign StageFlush = w_flush;
    assign State      = r_state;
    assign Halted     = (r_state == ST_HALTED);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a behavioural model pushes the expected
// outputs of each cycle into a scoreboard queue, each test pops and compares.
module tb_pipe_ctrl;

    typedef struct packed {
        logic [2:0]  state;
        logic [4:0]  en;
        logic [4:0]  flush;
        logic        halted;
        logic [15:0] cyc;
        logic [15:0] stall;
        logic [3:0]  cyc4;
    } obs_t;

    logic        Clock;
    logic        Reset;
    logic        RunReq, StepReq, HaltReq, HaltInstr, HazardStall, BranchTaken;
    logic [4:0]  StageEn, StageFlush, StageEn4, StageFlush4;
    logic [2:0]  State, State4;
    logic        Halted, Halted4;
    logic [15:0] CycleCount, StallCount;
    logic [3:0]  CycleCount4, StallCount4;

    obs_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state
    logic [2:0]  m_state;
    int          m_cnt;
    logic [15:0] m_cyc, m_stall;
    logic [3:0]  m_cyc4;

    pipe_ctrl #(.N_STAGES(5), .CNT_W(16)) u_dut (
        .Clock(Clock), .Reset(Reset), .RunReq(RunReq), .StepReq(StepReq),
        .HaltReq(HaltReq), .HaltInstr(HaltInstr), .HazardStall(HazardStall),
        .BranchTaken(BranchTaken), .StageEn(StageEn), .StageFlush(StageFlush),
        .State(State), .Halted(Halted), .CycleCount(CycleCount), .StallCount(StallCount)
    );

    pipe_ctrl #(.N_STAGES(5), .CNT_W(4)) u_dut4 (
        .Clock(Clock), .Reset(Reset), .RunReq(RunReq), .StepReq(StepReq),
        .HaltReq(HaltReq), .HaltInstr(HaltInstr), .HazardStall(HazardStall),
        .BranchTaken(BranchTaken), .StageEn(StageEn4), .StageFlush(StageFlush4),
        .State(State4), .Halted(Halted4), .CycleCount(CycleCount4), .StallCount(StallCount4)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic string fmt(input obs_t o);
        return $sformatf("st=%0d en=%b fl=%b h=%b cyc=%0d stl=%0d cyc4=%0d",
                         o.state, o.en, o.flush, o.halted, o.cyc, o.stall, o.cyc4);
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.state  = State;
        o.en     = StageEn;
        o.flush  = StageFlush;
        o.halted = Halted;
        o.cyc    = CycleCount;
        o.stall  = StallCount;
        o.cyc4   = CycleCount4;
        return o;
    endfunction

    // Expected outputs for the current cycle from model state and inputs
    function automatic obs_t model_out();
        obs_t o;
        o.state  = m_state;
        o.halted = (m_state == 3'd4);
        o.cyc    = m_cyc;
        o.stall  = m_stall;
        o.cyc4   = m_cyc4;
        o.en     = 5'b00000;
        o.flush  = 5'b00000;
        if (!Reset) begin
            o.flush = 5'b11111;
        end else if (m_state == 3'd1 || m_state == 3'd2) begin
            if (HazardStall) begin
                o.en    = 5'b11100;
                o.flush = 5'b00100;
            end else begin
                o.en    = 5'b11111;
                o.flush = BranchTaken ? 5'b00010 : 5'b00000;
            end
        end else if (m_state == 3'd3) begin
            o.en    = 5'b11100;
            o.flush = 5'b00100;
        end
        return o;
    endfunction

    task automatic model_step();
        logic active, stall;
        active = (m_state == 3'd1) || (m_state == 3'd2) || (m_state == 3'd3);
        stall  = ((m_state == 3'd1) || (m_state == 3'd2)) && HazardStall;
        if (!Reset) begin
            m_state = 3'd0; m_cnt = 0; m_cyc = '0; m_stall = '0; m_cyc4 = '0;
        end else begin
            if (active && m_cyc != 16'hFFFF) m_cyc = m_cyc + 16'd1;
            if (active && m_cyc4 != 4'hF) m_cyc4 = m_cyc4 + 4'd1;
            if (stall && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            case (m_state)
                3'd0: if (RunReq) m_state = 3'd1; else if (StepReq) m_state = 3'd2;
                3'd1, 3'd2: begin
                    if (HaltReq || (HaltInstr && !HazardStall)) begin
                        m_state = 3'd3; m_cnt = 3;
                    end else if (m_state == 3'd2 && !HazardStall) begin
                        m_state = 3'd0;
                    end
                end
                3'd3: begin
                    m_cnt = m_cnt - 1;
                    if (m_cnt == 0) m_state = 3'd4;
                end
                default: ;
            endcase
        end
    endtask

    // v = {rst_n, run, step, hreq, hinstr, haz, br}
    task automatic drive(input logic [6:0] v);
        {Reset, RunReq, StepReq, HaltReq, HaltInstr, HazardStall, BranchTaken} = v;
        #1;
        sb.push_back(model_out());
    endtask

    task automatic tick();
        @(posedge Clock);
        model_step();
        @(negedge Clock);
    endtask

    task automatic test_reset();
        logic [6:0] seq[] = '{7'b0100011, 7'b0011111, 7'b0000000};
        obs_t got, exp;
        foreach (seq[i]) begin
            drive(seq[i]);
            exp = sb.pop_front(); got = observe(); n_vec++;
            if (got !== exp) begin
                n_err++; $display("FAIL reset[%0d] got %s exp %s", i, fmt(got), fmt(exp));
            end else $display("reset[%0d] %s", i, fmt(got));
            tick();
        end
    endtask

    task automatic test_run();
        obs_t got, exp;
        for (int i = 0; i < 11; i++) begin
            drive(7'b1100000);
            exp = sb.pop_front(); got = observe(); n_vec++;
            if (got !== exp) begin
                n_err++; $display("FAIL run[%0d] got %s exp %s", i, fmt(got), fmt(exp));
            end else $display("run[%0d] %s", i, fmt(got));
            tick();
        end
        n_vec++;
        if (CycleCount !== 16'd10 || State !== 3'd1 || StageEn !== 5'b11111) begin
            n_err++; $display("FAIL run_10 got cyc=%0d st=%0d en=%b exp cyc=10 st=1 en=11111",
                              CycleCount, State, StageEn);
        end
    endtask

    task automatic test_hazard_branch();
        logic [6:0] seq[] = '{7'b1000011, 7'b1000001, 7'b1000000, 7'b1000010,
                              7'b1000110, 7'b1000010, 7'b1000001};
        obs_t got, exp;
        logic [15:0] stall0;
        stall0 = StallCount;
        foreach (seq[i]) begin
            drive(seq[i]);
            exp = sb.pop_front(); got = observe(); n_vec++;
            if (got !== exp) begin
                n_err++; $display("FAIL hazard[%0d] got %s exp %s", i, fmt(got), fmt(exp));
            end else $display("hazard[%0d] %s", i, fmt(got));
            tick();
        end
        n_vec++;
        if (StallCount !== stall0 + 16'd4 || State !== 3'd1) begin
            n_err++; $display("FAIL hazard_stalls got stl=%0d st=%0d exp stl=%0d st=1",
                              StallCount, State, stall0 + 16'd4);
        end
    endtask

    task automatic test_halt();
        logic [6:0] seq[] = '{7'b1001000, 7'b1000000, 7'b1000000, 7'b1000000,
                              7'b1100000, 7'b1110000, 7'b1100011};
        obs_t got, exp;
        foreach (seq[i]) begin
            drive(seq[i]);
            exp = sb.pop_front(); got = observe(); n_vec++;
            if (got !== exp) begin
                n_err++; $display("FAIL halt[%0d] got %s exp %s", i, fmt(got), fmt(exp));
            end else $display("halt[%0d] %s", i, fmt(got));
            tick();
        end
        n_vec++;
        if (Halted !== 1'b1 || State !== 3'd4 || StageEn !== 5'b00000) begin
            n_err++; $display("FAIL halt_final got h=%b st=%0d en=%b exp h=1 st=4 en=00000",
                              Halted, State, StageEn);
        end
    endtask

    task automatic test_step();
        // reset, step with hazard, two more stall cycles, release; then a
        // HaltReq arriving during a stall in STEP
        logic [6:0] seq[] = '{7'b0000000, 7'b1010010, 7'b1000010, 7'b1000010,
                              7'b1000000, 7'b1000000, 7'b1010000, 7'b1001010,
                              7'b1000000, 7'b1000000, 7'b1000000};
        obs_t got, exp;
        int step_cycles = 0, fetch_cycles = 0;
        foreach (seq[i]) begin
            drive(seq[i]);
            exp = sb.pop_front(); got = observe(); n_vec++;
            if (got !== exp) begin
                n_err++; $display("FAIL step[%0d] got %s exp %s", i, fmt(got), fmt(exp));
            end else $display("step[%0d] %s", i, fmt(got));
            if (i < 5 && got.state == 3'd2) begin
                step_cycles++;
                if (got.en[0]) fetch_cycles++;
            end
            tick();
        end
        n_vec++;
        if (step_cycles != 3 || fetch_cycles != 1 || State !== 3'd4) begin
            n_err++; $display("FAIL step_len got step=%0d fetch=%0d st=%0d exp step=3 fetch=1 st=4",
                              step_cycles, fetch_cycles, State);
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [6:0] seq[] = '{7'b0000000, 7'b1100000, 7'b1001000, 7'b1000000,
                              7'b0000000, 7'b1000000};
        obs_t got, exp;
        foreach (seq[i]) begin
            drive(seq[i]);
            exp = sb.pop_front(); got = observe(); n_vec++;
            if (got !== exp) begin
                n_err++; $display("FAIL rst_drain[%0d] got %s exp %s", i, fmt(got), fmt(exp));
            end else $display("rst_drain[%0d] %s", i, fmt(got));
            tick();
        end
        n_vec++;
        if (State !== 3'd0 || CycleCount !== 16'd0 || StallCount !== 16'd0) begin
            n_err++; $display("FAIL rst_drain_final got st=%0d cyc=%0d stl=%0d exp 0 0 0",
                              State, CycleCount, StallCount);
        end
    endtask

    task automatic test_saturate();
        obs_t got, exp;
        for (int i = 0; i < 21; i++) begin
            drive(i == 0 ? 7'b0000000 : 7'b1100000);
            exp = sb.pop_front(); got = observe(); n_vec++;
            if (got !== exp) begin
                n_err++; $display("FAIL sat[%0d] got %s exp %s", i, fmt(got), fmt(exp));
            end else $display("sat[%0d] %s", i, fmt(got));
            tick();
        end
        n_vec++;
        if (CycleCount4 !== 4'd15 || CycleCount !== 16'd19) begin
            n_err++; $display("FAIL sat_final got cyc4=%0d cyc=%0d exp cyc4=15 cyc=19",
                              CycleCount4, CycleCount);
        end
    endtask

    task automatic test_back_to_back();
        obs_t got, exp;
        logic [6:0] v;
        for (int i = 0; i < 300; i++) begin
            v[6] = ($urandom_range(0, 40) != 0);
            v[5] = ($urandom_range(0, 3) == 0);
            v[4] = ($urandom_range(0, 2) == 0);
            v[3] = ($urandom_range(0, 24) == 0);
            v[2] = ($urandom_range(0, 12) == 0);
            v[1] = ($urandom_range(0, 2) == 0);
            v[0] = ($urandom_range(0, 1) == 0);
            drive(v);
            exp = sb.pop_front(); got = observe(); n_vec++;
            if (got !== exp) begin
                n_err++; $display("FAIL rand[%0d] in=%b got %s exp %s", i, v, fmt(got), fmt(exp));
            end else $display("rand[%0d] in=%b %s", i, v, fmt(got));
            tick();
        end
    endtask

    initial begin
        {Reset, RunReq, StepReq, HaltReq, HaltInstr, HazardStall, BranchTaken} = 7'b0000000;
        m_state = 3'd0; m_cnt = 0; m_cyc = '0; m_stall = '0; m_cyc4 = '0;
        @(posedge Clock);
        model_step();
        @(negedge Clock);
        test_reset();
        test_run();
        test_hazard_branch();
        test_halt();
        test_step();
        test_reset_mid_drain();
        test_saturate();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter N_STAGES, default 5, the number of pipeline stage registers controlled (bit0=PC, bit1=IF/ID, bit2=ID/EX, bit3=EX/MEM, bit4=MEM/WB); legal range 4..8.
REQ-002 SHALL have parameter CNT_W, default 16, the width of the performance counters.
REQ-003 SHALL have port Clock  input  1  the single clock; all state changes on the rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port RunReq  input  1  level; start free-running execution from IDLE.
REQ-006 SHALL have port StepReq  input  1  pulse; execute one instruction fetch from IDLE.
REQ-007 SHALL have port HaltReq  input  1  external halt request.
REQ-008 SHALL have port HaltInstr  input  1  HALT opcode decoded in ID this cycle.
REQ-009 SHALL have port HazardStall  input  1  load-use/branch-operand hazard detected in ID.
REQ-010 SHALL have port BranchTaken  input  1  branch/jump resolved taken in ID.
REQ-011 SHALL have port StageEn  output  N_STAGES  per-stage register write enable.
REQ-012 SHALL have port StageFlush  output  N_STAGES  per-stage bubble insert (loads NOP/zero control).
REQ-013 SHALL have port State  output  3  current FSM state encoding.
REQ-014 SHALL have port Halted  output  1  high in HALTED.
REQ-015 SHALL have port CycleCount  output  CNT_W  active-cycle counter.
REQ-016 SHALL have port StallCount  output  CNT_W  hazard-stall counter.

Function
REQ-017 SHALL implement states IDLE, RUN, STEP, DRAIN, HALTED; State, counters and drain counter registered; StageEn/StageFlush combinational from state and inputs.
REQ-018 IDLE: StageEn=0, StageFlush=0; RunReq -> RUN; else StepReq -> STEP; RunReq wins if both.
REQ-019 RUN/STEP nominal cycle: StageEn all ones, StageFlush=0.
REQ-020 RUN/STEP with HazardStall=1: StageEn[1:0]=0, StageEn[N-1:2]=1, StageFlush[2]=1; BranchTaken and HaltInstr ignored that cycle.
REQ-021 RUN/STEP with BranchTaken=1, HazardStall=0: StageEn all ones, StageFlush[1]=1 (squash fetched instruction).
REQ-022 RUN/STEP with (HaltReq=1 or HaltInstr=1) and HazardStall=0: enables per nominal cycle, next state DRAIN, drain counter loaded with N_STAGES-2; HaltReq is honoured even when HazardStall=1 (stall enables still apply that cycle).
REQ-023 STEP: returns to IDLE after the first cycle with StageEn[0]=1 and no halt; stall cycles extend STEP.
REQ-024 DRAIN: StageEn[1:0]=0, StageEn[N-1:2]=1, StageFlush[2]=1; counter decrements each cycle; at 0 -> HALTED (DRAIN lasts exactly N_STAGES-2 cycles); all other inputs ignored.
REQ-025 HALTED: StageEn=0, StageFlush=0, Halted=1; terminal until reset.
REQ-026 CycleCount SHALL increment each cycle in RUN, STEP or DRAIN, saturating at 2^CNT_W-1.
REQ-027 StallCount SHALL increment each RUN/STEP cycle with HazardStall=1, saturating at 2^CNT_W-1.
REQ-028 Illegal State encodings SHALL transition to IDLE on the next edge.

Reset
REQ-029 Reset=0 at a rising edge SHALL force IDLE, drain counter 0, CycleCount=0, StallCount=0, Halted=0, from any state including mid-DRAIN.
REQ-030 While Reset=0, StageEn=0 and StageFlush=all ones.

Structure
REQ-031 State encodings (IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4) and stage-index constants (PC, IFID, IDEX, EXMEM, MEMWB) SHALL live in shared package pipe_pkg.
REQ-032 The saturating counter SHALL be one sub-module, sat_counter (parameter W, inputs Clock, Reset, Inc), instantiated twice.

Verification
REQ-033 Reset then RunReq=1 for 10 cycles -> State=RUN from cycle 1, StageEn=5'b11111, CycleCount=10.
REQ-034 RUN, HazardStall=1 and BranchTaken=1 same cycle -> StageEn=5'b11100, StageFlush=5'b00100, StallCount +1; next cycle BranchTaken alone -> StageFlush=5'b00010.
REQ-035 StepReq pulse with HazardStall=1 for 2 cycles -> STEP lasts 3 cycles, exactly one cycle with StageEn[0]=1, then IDLE.
REQ-036 RUN, HaltInstr=1 -> DRAIN for 3 cycles with StageEn=5'b11100, then HALTED, Halted=1, StageEn=0; RunReq ignored afterwards.
REQ-037 Reset=0 in 2nd DRAIN cycle -> IDLE next edge, both counters 0, StageFlush=all ones during reset.
REQ-038 CNT_W=4, RUN 20 cycles -> CycleCount holds 15.
